// File: rtl/wmc_timer20_if.sv
// Signal bundle between the washing-machine controller and its phase timer.
// The controller (master) drives the request level and phase tag; the timer
// (slave) returns the expiry pulse, busy flag and remaining minutes.
// There is no valid/ready pair: T20START is a level and T20DONE is a
// single-cycle pulse that the controller samples on the next falling edge.
interface wmc_timer20_if;
    logic       T20START;
    logic [2:0] STAGE;
    logic       T20DONE;
    logic       BUSY;
    logic [4:0] REMAIN_MIN;

    modport master (
        output T20START,
        output STAGE,
        input  T20DONE,
        input  BUSY,
        input  REMAIN_MIN
    );

    modport slave (
        input  T20START,
        input  STAGE,
        output T20DONE,
        output BUSY,
        output REMAIN_MIN
    );
endinterface

// File: rtl/wmc_timer20.sv
// Phase timer for the washing-machine controller. Counts DURATION_MIN
// minutes of CLK_PER_MIN clocks each, restarting on every new phase and
// emitting a one-cycle T20DONE pulse on expiry. All state moves on the
// falling edge of CLOCK; RESET is asynchronous and active-high.
module wmc_timer20 #(
    parameter int CLK_PER_MIN  = 3000,
    parameter int DURATION_MIN = 20
) (
    input  logic          CLOCK,
    input  logic          RESET,
    wmc_timer20_if.slave  tif,
    output logic [1:0]    dbg_state_o
);

    localparam int PW = (CLK_PER_MIN > 1) ? $clog2(CLK_PER_MIN) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MIN - 1);
    localparam logic [4:0]    DUR        = 5'(DURATION_MIN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_EXPIRE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [4:0]      remain_q, remain_d;
    logic            start_q;
    logic [2:0]      stage_q;
    logic            restart;

    // A new phase is a rising request or a phase tag change while requested;
    // the latter covers back-to-back phases where T20START never drops.
    assign restart = tif.T20START & (~start_q | (tif.STAGE != stage_q));

    // Shadow copies of the request and phase tag, taken every falling edge.
    always_ff @(negedge CLOCK or posedge RESET) begin
        if (RESET) begin
            start_q <= 1'b0;
            stage_q <= 3'b000;
        end else begin
            start_q <= tif.T20START;
            stage_q <= tif.STAGE;
        end
    end

    // State, prescaler and minute counter registers.
    always_ff @(negedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            remain_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            remain_q <= remain_d;
        end
    end

    // Next state: abort beats restart, restart beats the per-state rule, so a
    // phase change on the expiry edge reloads silently instead of pulsing.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        remain_d = remain_q;
        if (!tif.T20START) begin
            state_d  = ST_IDLE;
            presc_d  = '0;
            remain_d = 5'd0;
        end else if (restart) begin
            state_d  = ST_RUN;
            presc_d  = '0;
            remain_d = DUR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d  = '0;
                        remain_d = remain_q - 5'd1;
                        if (remain_q <= 5'd1) begin
                            remain_d = 5'd0;
                            state_d  = ST_EXPIRE;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                ST_EXPIRE: begin
                    state_d  = ST_HOLD;
                    presc_d  = '0;
                    remain_d = 5'd0;
                end
                ST_HOLD: begin
                    state_d  = ST_HOLD;
                    presc_d  = '0;
                    remain_d = 5'd0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    presc_d  = '0;
                    remain_d = 5'd0;
                end
            endcase
        end
    end

    // Moore outputs decoded from registered state only.
    assign tif.T20DONE    = (state_q == ST_EXPIRE);
    assign tif.BUSY       = (state_q == ST_RUN);
    assign tif.REMAIN_MIN = remain_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_wmc_timer20.sv
// Directed bench for wmc_timer20 with CLK_PER_MIN=4, DURATION_MIN=3.
// Inputs change on the rising edge and outputs are read there too, so every
// value is stable relative to the falling edge the DUT acts on.
module tb_wmc_timer20;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [1:0] dbg_state;
    int         total = 0;
    int         bad   = 0;

    wmc_timer20_if tif();

    wmc_timer20 #(
        .CLK_PER_MIN  (4),
        .DURATION_MIN (3)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .tif         (tif),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    always #5 CLOCK = ~CLOCK;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK);
    endtask

    // Hand-derived profile of one run: r counts falling edges since restart.
    function automatic int exp_rem(input int r);
        if (r < 4)       return 3;
        else if (r < 8)  return 2;
        else if (r < 12) return 1;
        else             return 0;
    endfunction

    // Called right after the edge where a restart was detected (r=0),
    // ends on the edge where T20DONE is high (r=12).
    task automatic watch_run(input string tag);
        for (int j = 0; j <= 12; j++) begin
            if (j > 0) step(1);
            check({tag, "_rem"},  32'(tif.REMAIN_MIN), 32'(exp_rem(j)));
            check({tag, "_busy"}, 32'(tif.BUSY),       (j < 12) ? 32'd1 : 32'd0);
            check({tag, "_done"}, 32'(tif.T20DONE),    (j == 12) ? 32'd1 : 32'd0);
        end
    endtask

    logic [2:0] phases [3];
    int cnt;
    int pulses;
    bit seen;

    initial begin
        phases[0] = 3'b001;
        phases[1] = 3'b010;
        phases[2] = 3'b100;
        RESET        = 1'b1;
        tif.T20START = 1'b0;
        tif.STAGE    = 3'b000;
        #2;
        check("rst_done",  32'(tif.T20DONE),    32'd0);
        check("rst_busy",  32'(tif.BUSY),       32'd0);
        check("rst_rem",   32'(tif.REMAIN_MIN), 32'd0);
        check("rst_state", 32'(dbg_state),      32'd0);
        step(2);
        RESET = 1'b0;
        step(2);
        check("idle_busy", 32'(tif.BUSY), 32'd0);

        // basic count
        tif.STAGE    = 3'b001;
        tif.T20START = 1'b1;
        step(1);
        watch_run("basic");
        step(1);
        check("hold_done",  32'(tif.T20DONE),    32'd0);
        check("hold_busy",  32'(tif.BUSY),       32'd0);
        check("hold_rem",   32'(tif.REMAIN_MIN), 32'd0);
        check("hold_state", 32'(dbg_state),      32'd3);

        // back-to-back phase, request held high
        tif.STAGE = 3'b010;
        step(1);
        watch_run("b2b");
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("b2b_hold_done", 32'(tif.T20DONE), 32'd0);
            check("b2b_hold_busy", 32'(tif.BUSY),    32'd0);
        end

        // abort at edge 7 of a run
        tif.T20START = 1'b0;
        step(1);
        tif.STAGE    = 3'b100;
        tif.T20START = 1'b1;
        step(1);
        check("abort_start_rem", 32'(tif.REMAIN_MIN), 32'd3);
        step(6);
        tif.T20START = 1'b0;
        step(1);
        check("abort_busy",  32'(tif.BUSY),       32'd0);
        check("abort_rem",   32'(tif.REMAIN_MIN), 32'd0);
        check("abort_state", 32'(dbg_state),      32'd0);
        for (int i = 0; i < 15; i++) begin
            step(1);
            check("abort_nodone", 32'(tif.T20DONE), 32'd0);
        end
        tif.T20START = 1'b1;
        step(1);
        check("rerun_rem",  32'(tif.REMAIN_MIN), 32'd3);
        check("rerun_busy", 32'(tif.BUSY),       32'd1);

        // phase change on the would-be expiry edge
        step(11);
        check("race_pre_rem", 32'(tif.REMAIN_MIN), 32'd1);
        tif.STAGE = 3'b001;
        step(1);
        check("race_done", 32'(tif.T20DONE),    32'd0);
        check("race_rem",  32'(tif.REMAIN_MIN), 32'd3);
        check("race_busy", 32'(tif.BUSY),       32'd1);
        watch_run("after_race");
        step(1);

        // asynchronous reset in the middle of a run
        tif.STAGE = 3'b010;
        step(1);
        step(5);
        #3;
        RESET = 1'b1;
        #1;
        check("mid_rst_done",  32'(tif.T20DONE),    32'd0);
        check("mid_rst_busy",  32'(tif.BUSY),       32'd0);
        check("mid_rst_rem",   32'(tif.REMAIN_MIN), 32'd0);
        check("mid_rst_state", 32'(dbg_state),      32'd0);
        step(2);
        RESET = 1'b0;
        step(1);
        check("post_rst_busy", 32'(tif.BUSY),       32'd1);
        check("post_rst_rem",  32'(tif.REMAIN_MIN), 32'd3);

        // integration with a controller model: WASH -> RINSE -> DRY -> DONE
        tif.T20START = 1'b0;
        tif.STAGE    = 3'b000;
        step(3);
        pulses = 0;
        for (int p = 0; p < 3; p++) begin
            tif.STAGE    = phases[p];
            tif.T20START = 1'b1;
            cnt  = 0;
            seen = 1'b0;
            while (!seen && cnt < 100) begin
                step(1);
                cnt++;
                if (tif.T20DONE === 1'b1) begin
                    seen = 1'b1;
                    pulses++;
                end
            end
            check("ctl_seen", 32'(seen), 32'd1);
            // the controller advances on the edge after it sees the pulse
            step(1);
            cnt++;
            check("ctl_pulse_width", 32'(tif.T20DONE), 32'd0);
            check("ctl_phase_len",   32'(cnt),         32'd14);
        end
        tif.T20START = 1'b0;
        tif.STAGE    = 3'b000;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (tif.T20DONE === 1'b1) pulses++;
            check("ctl_idle_busy", 32'(tif.BUSY), 32'd0);
        end
        check("ctl_pulses", 32'(pulses), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
